// File: rtl/ad_ip_jesd204_tpl_adc_pack.sv
// JESD204 TPL ADC channel packer: drops disabled channels, packs beats into words.
// Optional: AD_IP_JESD204_TPL_ADC_PACK_OVF_STICKY_EN makes the overflow flag sticky.
module ad_ip_jesd204_tpl_adc_pack #(
  parameter int NUM_CHANNELS        = 4,
  parameter int SAMPLES_PER_CHANNEL = 1,
  parameter int SAMPLE_DATA_WIDTH   = 16,
  localparam int DW = NUM_CHANNELS * SAMPLES_PER_CHANNEL * SAMPLE_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NUM_CHANNELS-1:0] enable,
  input  logic                    fifo_wr_en,
  input  logic [DW-1:0]           fifo_wr_data,
  output logic                    fifo_wr_overflow,
  output logic                    packed_fifo_wr_en,
  output logic                    packed_fifo_wr_sync,
  output logic [DW-1:0]           packed_fifo_wr_data,
  input  logic                    packed_fifo_wr_overflow,
  output logic                    cfg_error
);

  localparam int NC  = NUM_CHANNELS;
  localparam int SPC = SAMPLES_PER_CHANNEL;
  localparam int SDW = SAMPLE_DATA_WIDTH;
  localparam int JW  = (NC > 1) ? $clog2(NC) : 1;

  logic [NC-1:0] enable_d;
  logic [JW-1:0] beat_cnt;
  logic          sync_pend;
  logic [DW-1:0] acc;

  int            n_en;
  int            bw;
  int            shift;
  int            k;
  logic          changed;
  logic          cfg_bad;
  logic          accept;
  logic          word_done;
  logic          sync_eff;
  logic [JW-1:0] j_eff;
  logic [DW-1:0] smp;
  logic [DW-1:0] compact;
  logic [DW-1:0] mask;
  logic [DW-1:0] word_next;

  // Decode enable: count, validity, slot position and word completion.
  always_comb begin
    n_en = 0;
    for (int c = 0; c < NC; c++) begin
      n_en = n_en + int'(enable[c]);
    end
    cfg_bad   = (n_en == 0) || ((n_en & (n_en - 1)) != 0);
    changed   = (enable != enable_d);
    accept    = fifo_wr_en && !cfg_bad;
    sync_eff  = sync_pend || changed;
    j_eff     = changed ? '0 : beat_cnt;
    bw        = n_en * SPC * SDW;
    shift     = int'(j_eff) * bw;
    word_done = ((int'(j_eff) + 1) * n_en) == NC;
  end

  // Compact enabled samples, sample-major, lowest channel first.
  always_comb begin
    compact = '0;
    smp     = '0;
    k       = 0;
    for (int s = 0; s < SPC; s++) begin
      for (int c = 0; c < NC; c++) begin
        if (enable[c]) begin
          smp = '0;
          smp[SDW-1:0] = fifo_wr_data[(c*SPC+s)*SDW +: SDW];
          compact = compact | (smp << (k * SDW));
          k = k + 1;
        end
      end
    end
  end

  // Drop the compacted beat into its slot of the word being built.
  always_comb begin
    mask      = {DW{1'b1}} >> (DW - bw);
    word_next = (acc & ~(mask << shift)) | (compact << shift);
  end

  // Beat counter, accumulator, sync tracking and word output.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      enable_d            <= '0;
      beat_cnt            <= '0;
      sync_pend           <= 1'b1;
      acc                 <= '0;
      cfg_error           <= 1'b0;
      packed_fifo_wr_en   <= 1'b0;
      packed_fifo_wr_sync <= 1'b0;
      packed_fifo_wr_data <= '0;
    end else begin
      enable_d            <= enable;
      cfg_error           <= cfg_bad;
      packed_fifo_wr_en   <= 1'b0;
      packed_fifo_wr_sync <= 1'b0;
      sync_pend           <= sync_eff;
      beat_cnt            <= j_eff;
      if (accept) begin
        acc <= word_next;
        if (word_done) begin
          packed_fifo_wr_en   <= 1'b1;
          packed_fifo_wr_sync <= sync_eff;
          packed_fifo_wr_data <= word_next;
          beat_cnt            <= '0;
          sync_pend           <= 1'b0;
        end else begin
          beat_cnt <= j_eff + 1'b1;
        end
      end
    end
  end

  // Overflow back to the TPL, optionally held until an enable change.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fifo_wr_overflow <= 1'b0;
    end else begin
`ifdef AD_IP_JESD204_TPL_ADC_PACK_OVF_STICKY_EN
      fifo_wr_overflow <= packed_fifo_wr_overflow |
                          (fifo_wr_overflow & ~changed);
`else
      fifo_wr_overflow <= packed_fifo_wr_overflow;
`endif
    end
  end

endmodule
